// File: rtl/commit_ctrl.sv
`default_nettype none
// ============================================================================
// commit_ctrl : in-order ROB retirement sequencer (commit, store handshake, flush)
// Revision    : 1.0 - initial release
// ============================================================================
module commit_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [3:0]           head_rob_index,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_val,
    input  logic                 head_is_store,
    input  logic                 head_mispredict,
    input  logic [31:0]          head_target,
    output logic                 head_pop,
    output logic                 reg_commit,
    output logic [3:0]           reg_rob_index,
    output logic [4:0]           reg_index,
    output logic [31:0]          reg_val,
    output logic                 store_go,
    input  logic                 store_done,
    output logic                 clr_out,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [CNT_WIDTH-1:0] commit_cnt
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] flush_cnt;
    logic       active;
    logic       start_flush;

    // Strobes are also gated by reset so nothing leaks out while rst_in is low.
    assign active = rdy_in && rst_in;

    always_comb begin
        next_state    = state;
        head_pop      = 1'b0;
        reg_commit    = 1'b0;
        reg_rob_index = '0;
        reg_index     = '0;
        reg_val       = '0;
        store_go      = 1'b0;
        start_flush   = 1'b0;
        if (active) begin
            case (state)
                IDLE: begin
                    if (head_valid && head_ready) begin
                        if (head_is_store) begin
                            store_go   = 1'b1;
                            next_state = STORE_WAIT;
                        end else begin
                            reg_commit    = 1'b1;
                            head_pop      = 1'b1;
                            reg_rob_index = head_rob_index;
                            reg_index     = head_rd;
                            reg_val       = head_val;
                            if (head_mispredict) begin
                                start_flush = 1'b1;
                                next_state  = FLUSH;
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    if (store_done) begin
                        head_pop   = 1'b1;
                        next_state = IDLE;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Clear is issued the edge after the link commit so the regfile never drops it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            flush_cnt      <= 4'd0;
            clr_out        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            commit_cnt     <= '0;
        end else if (rdy_in) begin
            state          <= next_state;
            clr_out        <= start_flush;
            redirect_valid <= start_flush;
            if (start_flush) begin
                redirect_pc <= head_target;
                flush_cnt   <= 4'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
            if (head_pop) begin
                commit_cnt <= commit_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- In-order retirement sequencer between the reorder buffer head and the register file write/commit port.
- Decides each cycle whether the ROB head retires, drives the register-file commit strobe and payload, and pops the head.
- Sequences store retirement through a go/done handshake with the load-store buffer.
- On a mispredicted branch, broadcasts a one-cycle pipeline clear plus a PC redirect, then holds off commits for a fixed flush window.

Parameters:
- FLUSH_CYCLES, 2, cycles spent in FLUSH after the clear pulse; legal range 1..15.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global enable; low freezes all state.
- head_valid  input  1  ROB non-empty.
- head_ready  input  1  head result is available.
- head_rob_index  input  4  head ROB index; never 0 (0 means "no dependency").
- head_rd  input  5  destination register; 0 means no write.
- head_val  input  32  result value.
- head_is_store  input  1  head is a store.
- head_mispredict  input  1  head is a resolved, mispredicted branch or jump.
- head_target  input  32  correct PC for a mispredict.
- head_pop  output  1  ROB advances its head at this edge.
- reg_commit  output  1  drives rob_to_reg_commit.
- reg_rob_index  output  4  drives rob_to_reg_rob_index.
- reg_index  output  5  drives rob_to_reg_index.
- reg_val  output  32  drives rob_to_reg_val.
- store_go  output  1  one-cycle pulse; LSB may write memory.
- store_done  input  1  LSB finished the store; single-cycle pulse.
- clr_out  output  1  pipeline clear; feeds every clr_in.
- redirect_valid  output  1  fetch redirect strobe.
- redirect_pc  output  32  redirect target.
- commit_cnt  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: IDLE, STORE_WAIT, FLUSH. State, flush counter, clr_out, redirect_valid, redirect_pc and commit_cnt are registered.
- head_pop, reg_commit, reg_* and store_go are combinational from current state and head inputs (Mealy). This gives one retirement per cycle and no duplicate-commit hazard.
- Reset (rst_in=0, asynchronous): state IDLE, flush counter 0, all registered outputs 0. Combinational outputs evaluate to 0 in IDLE with head_valid=0. Reset mid-store or mid-flush aborts to IDLE.
- rdy_in=0: every combinational strobe is forced to 0; no registered state or output changes. A pending store_done is held off by the LSB, which also honours rdy_in.
- Retire condition: state is IDLE, rdy_in=1, head_valid=1, head_ready=1. Otherwise no strobes.
- IDLE, normal head (not store, not mispredict):
  - reg_commit=1, head_pop=1, reg_* copied from head.
  - commit_cnt+1 at the edge; stay in IDLE.
  - head_rd=0 still asserts reg_commit; the regfile discards writes to x0.
- IDLE, store head:
  - store_go=1 for this cycle only; no pop, no commit; next state STORE_WAIT.
- STORE_WAIT:
  - When store_done=1: head_pop=1, reg_commit=0, commit_cnt+1, next state IDLE.
  - While store_done=0: hold, all strobes 0.
- IDLE, mispredict head:
  - reg_commit=1 with link value and head_pop=1 this cycle; commit_cnt+1.
  - Next edge: clr_out=1, redirect_valid=1, redirect_pc=head_target, counter=FLUSH_CYCLES, state FLUSH.
  - clr_out is deliberately one cycle after the commit, so the regfile's clear-priority branch cannot drop the link write.
- FLUSH:
  - clr_out and redirect_valid are high only in the first FLUSH cycle and cleared on the following edge.
  - Counter decrements each enabled cycle; when the counter is 1 at an edge, next state is IDLE.
  - Head inputs are ignored throughout FLUSH.
- Store and mispredict are never set together. If both are high, store takes precedence and the mispredict flag is ignored (verification asserts this never occurs).
- commit_cnt wraps modulo 2^CNT_WIDTH.

Test Plan:
- Reset: hold rst_in=0 with random inputs -> all outputs 0; release -> still 0 while head_valid=0.
- Three ready ALU heads on consecutive cycles (idx 1,2,3; rd 5,6,7; vals 0x11,0x22,0x33) -> reg_commit and head_pop high 3 consecutive cycles with matching payload; commit_cnt=3.
- Store head (idx 4), store_done 5 cycles after store_go -> store_go is a single pulse; head_pop exactly in the store_done cycle; reg_commit never high; commit_cnt+1.
- Mispredict JAL (idx 5, rd 1, val 0x1004, target 0x2000), FLUSH_CYCLES=2 -> commit cycle T; clr_out, redirect_valid and redirect_pc=0x2000 in cycle T+1 only; a ready head offered at T+1..T+2 is not popped; retirement resumes at T+3.
- rdy_in=0 during STORE_WAIT and during FLUSH -> state, counter and commit_cnt frozen; strobes 0; correct resumption when rdy_in returns to 1.
- Reset asserted while in FLUSH with counter=2 -> IDLE and all outputs 0 immediately, without waiting for a clock edge.
